// File: rtl/lcd_frame_prefetch.sv
// Read-side pixel prefetcher for lcd_driver: fetches fixed-length SDRAM bursts
// into a local FIFO and pops one pixel per lcd_request, restarting on each frame sync.
module lcd_frame_prefetch #(
  parameter int DATA_W      = 16,
  parameter int FIFO_AW     = 9,
  parameter int BURST_LEN   = 256,
  parameter int SDRAM_AW    = 22,
  parameter int FRAME_WORDS = 737280
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lcd_framesync,
  input  logic                lcd_request,
  output logic [DATA_W-1:0]   lcd_data,
  output logic                burst_req,
  output logic [SDRAM_AW-1:0] burst_addr,
  input  logic                burst_ack,
  input  logic                rd_valid,
  input  logic [DATA_W-1:0]   rd_data,
  output logic [FIFO_AW:0]    fifo_level,
  output logic                underflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]  DEPTH_L   = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]  BURST_L   = (FIFO_AW+1)'(BURST_LEN);
  localparam logic [SDRAM_AW:0] BURST_A   = (SDRAM_AW+1)'(BURST_LEN);
  localparam logic [SDRAM_AW:0] FRAME_END = (SDRAM_AW+1)'(FRAME_WORDS);

  typedef enum logic [2:0] {IDLE, REQ, RECV, DRAIN, FLUSH} state_t;

  state_t               state, state_nxt;
  logic                 framesync_p0;
  logic                 fs_pulse;
  logic [DATA_W-1:0]    mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW:0]     beat_cnt;
  logic                 frame_done;
  logic [SDRAM_AW:0]    next_addr;
  logic                 push, pop, recv_beat, last_beat;

  always_comb begin
    fs_pulse  = framesync_p0 & ~lcd_framesync;
    recv_beat = rd_valid && (state == RECV || state == DRAIN);
    last_beat = recv_beat && (beat_cnt == BURST_L - 1'b1);
    push      = rd_valid && (state == RECV);
    pop       = lcd_request && (fifo_level != '0) && (state != FLUSH);
    next_addr = {1'b0, burst_addr} + BURST_A;
  end

  assign burst_req = (state == REQ);

  // A completing burst always finishes its beat count before any flush, so the
  // SDRAM side never sees a burst abandoned mid-flight.
  always_comb begin
    state_nxt = state;
    case (state)
      FLUSH: state_nxt = IDLE;
      IDLE: begin
        if (fs_pulse)
          state_nxt = FLUSH;
        else if (!frame_done && (DEPTH_L - fifo_level) >= BURST_L)
          state_nxt = REQ;
      end
      REQ: begin
        if (burst_ack)
          state_nxt = fs_pulse ? DRAIN : RECV;
        else if (fs_pulse)
          state_nxt = FLUSH;
      end
      RECV: begin
        if (last_beat)
          state_nxt = fs_pulse ? FLUSH : IDLE;
        else if (fs_pulse)
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (last_beat)
          state_nxt = FLUSH;
      end
      default: state_nxt = FLUSH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FLUSH;
      framesync_p0 <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      beat_cnt     <= '0;
      burst_addr   <= '0;
      frame_done   <= 1'b0;
      underflow    <= 1'b0;
      lcd_data     <= '0;
    end else begin
      state        <= state_nxt;
      framesync_p0 <= lcd_framesync;

      if (state == FLUSH) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
        burst_addr <= '0;
        frame_done <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   fifo_level <= fifo_level + 1'b1;
          2'b01:   fifo_level <= fifo_level - 1'b1;
          default: fifo_level <= fifo_level;
        endcase
        // Address only advances on a burst that landed in the FIFO.
        if (state == RECV && last_beat) begin
          if (next_addr == FRAME_END) begin
            burst_addr <= '0;
            frame_done <= 1'b1;
          end else begin
            burst_addr <= next_addr[SDRAM_AW-1:0];
          end
        end
      end

      if (state == REQ && burst_ack)
        beat_cnt <= '0;
      else if (recv_beat)
        beat_cnt <= beat_cnt + 1'b1;

      if (lcd_request && fifo_level == '0)
        underflow <= 1'b1;

      // Pixel output stage: one cycle after the request
      lcd_data <= pop ? mem[rd_ptr] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rd_data;
  end

endmodule
